// File: rtl/ikari_rom_toggle_responder.sv
// rtl/ikari_rom_toggle_responder.sv - toggle req/ack ROM fetch responder on one SDRAM read port
// Optional one-entry response cache is enabled by defining ROM_RESP_CACHE_EN.
module ikari_rom_toggle_responder #(
    parameter int unsigned       ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              VIDEO_RSTn,
    input  logic [23:0]       rom_addr,
    input  logic              rom_req,
    output logic              rom_ack,
    output logic [15:0]       rom_data,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic              sdram_busy,
    input  logic              sdram_valid,
    input  logic [15:0]       sdram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            r_state;
    logic              r_rom_ack;
    logic [15:0]       r_rom_data;
    logic [ADDR_W-1:0] r_addr_q;
    logic              r_sdram_rd;
    logic              r_busy;
    logic [2:0]        r_retry;

`ifdef ROM_RESP_CACHE_EN
    logic              r_cache_vld;
    logic [ADDR_W-1:0] r_last_addr;
    logic [15:0]       r_last_data;
`endif

    logic [ADDR_W-1:0] w_req_addr;
    logic              w_pending;

    assign w_req_addr = BASE_ADDR + ADDR_W'(rom_addr);
    assign w_pending  = rom_req != r_rom_ack;

    assign rom_ack    = r_rom_ack;
    assign rom_data   = r_rom_data;
    assign sdram_addr = r_addr_q;
    assign sdram_rd   = r_sdram_rd;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            r_state    <= S_IDLE;
            r_rom_ack  <= 1'b0;
            r_rom_data <= 16'h0000;
            r_addr_q   <= '0;
            r_sdram_rd <= 1'b0;
            r_busy     <= 1'b0;
            r_retry    <= 3'd0;
`ifdef ROM_RESP_CACHE_EN
            r_cache_vld <= 1'b0;
            r_last_addr <= '0;
            r_last_data <= 16'h0000;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pending) begin
`ifdef ROM_RESP_CACHE_EN
                        if (r_cache_vld && (w_req_addr == r_last_addr)) begin
                            r_rom_data <= r_last_data;
                            r_rom_ack  <= ~r_rom_ack;
                        end else
`endif
                        begin
                            r_addr_q   <= w_req_addr;
                            r_retry    <= 3'd0;
                            r_sdram_rd <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // sdram_valid is deliberately ignored here: it can only be a late strobe.
                    if (!sdram_busy) begin
                        r_sdram_rd <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdram_valid) begin
                        if (!w_pending) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if ((w_req_addr == r_addr_q) || (r_retry == 3'(MAX_RETRY))) begin
                            r_rom_data <= sdram_dout;
                            r_rom_ack  <= ~r_rom_ack;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
`ifdef ROM_RESP_CACHE_EN
                            r_cache_vld <= 1'b1;
                            r_last_addr <= r_addr_q;
                            r_last_data <= sdram_dout;
`endif
                        end else begin
                            // Client moved on while we waited: refetch at its current address.
                            r_addr_q   <= w_req_addr;
                            r_retry    <= r_retry + 3'd1;
                            r_sdram_rd <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    r_sdram_rd <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ikari_rom_toggle_responder.md
Name: ikari_rom_toggle_responder

Overview:
- SDRAM-side responder for the toggle request/acknowledge ROM fetch interface that the video layers (BACK1, BACK2, sprites) use as initiators.
- Detects a pending request when rom_req differs from rom_ack, performs one 16-bit word read on an SDRAM controller read port, returns the word on rom_data and toggles rom_ack.
- Sits between one video-layer client and one SDRAM controller channel in the core top level.
- Guarantees rom_data belongs to the client's current rom_addr whenever it acknowledges, except when the retry cap is hit.

Parameters:
- ADDR_W, 25, SDRAM word-address width.
- BASE_ADDR, 25'h0, word offset of this client's ROM region; added to rom_addr modulo 2^ADDR_W.
- MAX_RETRY, 2, maximum stale-address reissues per request before acknowledging anyway; allowed range 0..7.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- VIDEO_RSTn  in  1  reset, asynchronous assert, active-low.
- rom_addr  in  24  client word address; may change at any time.
- rom_req  in  1  client request toggle.
- rom_ack  out  1  acknowledge toggle; a request is pending while rom_req != rom_ack.
- rom_data  out  16  returned ROM word.
- sdram_addr  out  ADDR_W  read address to the SDRAM controller.
- sdram_rd  out  1  read request level.
- sdram_busy  in  1  controller cannot accept a read this cycle.
- sdram_valid  in  1  one-cycle strobe; sdram_dout is valid.
- sdram_dout  in  16  read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous):
  - rom_ack=0, rom_data=16'h0000, sdram_addr=0, sdram_rd=0, busy=0.
  - state=IDLE, retry counter=0, captured address addr_q=0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If rom_req != rom_ack: addr_q <= BASE_ADDR + rom_addr (zero-extended, sum truncated to ADDR_W), retry counter <= 0, go to ISSUE.
- ISSUE:
  - sdram_rd=1 and sdram_addr=addr_q, registered outputs.
  - The read is accepted on the cycle where sdram_rd=1 and sdram_busy=0. On that cycle go to WAIT; sdram_rd is 0 from the next cycle.
  - sdram_rd stays high for as long as sdram_busy=1.
- WAIT, on sdram_valid:
  - If BASE_ADDR + rom_addr == addr_q, or the retry counter == MAX_RETRY: rom_data <= sdram_dout and rom_ack <= ~rom_ack on the same edge, then go to IDLE.
  - Otherwise (stale address): addr_q <= BASE_ADDR + rom_addr, retry counter +1, go to ISSUE. Neither rom_data nor rom_ack changes.
- rom_data changes only on the acknowledge edge, so it is stable whenever rom_req == rom_ack.
- Latency for an idle controller (sdram_busy=0) is 2 cycles + controller read latency + 1, measured from the rom_req edge to the rom_ack edge.
- rom_req toggles again while a request is pending (returns to equal rom_ack before the acknowledge): treated as cancelled. On the next sdram_valid, discard the data, do not toggle rom_ack, go to IDLE.
- sdram_valid in IDLE or ISSUE is ignored; this covers late strobes after a reset.
- Reset during ISSUE or WAIT returns to IDLE immediately. The response to the outstanding read is dropped.
- Back-to-back requests: a new request is recognised in IDLE on the cycle after the acknowledge.

Optional Feature:
- ROM_RESP_CACHE_EN defined:
  - Adds a one-entry cache: last_addr and last_data plus a valid bit, cleared on reset.
  - Written on every acknowledge.
  - In IDLE, if a request is pending, valid=1 and BASE_ADDR + rom_addr == last_addr: rom_data <= last_data and rom_ack toggles on the next edge. No SDRAM access; state stays IDLE (1-cycle response).
- ROM_RESP_CACHE_EN undefined: no cache; every request goes to SDRAM.

Test Plan:
- Basic read: BASE_ADDR=25'h40000; rom_addr=24'h00123, toggle rom_req; controller latency 3 with data 16'hA55A -> sdram_addr=25'h40123, sdram_rd high exactly 1 cycle, rom_data=16'hA55A, rom_ack toggles 6 cycles after the rom_req edge.
- Busy stall: sdram_busy held high 4 cycles -> sdram_rd held high 5 cycles, sdram_addr stable throughout, exactly one read accepted.
- Stale reissue: rom_addr changes from 24'h10 to 24'h11 during WAIT -> second read at BASE+24'h11, rom_ack toggles only after the second sdram_valid, rom_data equals the second read's data.
- Retry cap: MAX_RETRY=2 and rom_addr changes on every read -> exactly 3 reads issued, then rom_ack toggles with the third read's data.
- Reset mid-WAIT: VIDEO_RSTn pulsed low, then sdram_valid arrives -> all outputs at reset values, rom_ack stays 0, the strobe is ignored.
- Cache (ROM_RESP_CACHE_EN): repeat the same rom_addr after an acknowledge -> no sdram_rd, rom_ack toggles 1 cycle after the rom_req edge, rom_data equals the prior word.
